vram_scanout: RTL and testbench
===============================

# vram_scanout

Display-side reader of the 640x480, 12-bit-per-pixel frame buffer that the graphics processor writes. It generates 640x480@60 VGA timing, issues one VRAM read per visible pixel in raster order, and drives 4-bit R/G/B plus active-low syncs. Pipeline delay compensates for the VRAM read latency. A vertical-blank pulse and level tell the drawing side when it can write without tearing.

## Interface

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- RD_LATENCY, 1, pix_en ticks from vram_re/vram_addr to valid vram_q; legal range 1..4

Ports:
- clk  in  1  system clock; one clock domain
- rstn  in  1  reset; synchronous, active-low
- pix_en  in  1  pixel strobe (25 MHz rate); all state advances only on clk edges where pix_en=1
- vram_re  out  1  read strobe for the pixel addressed this tick
- vram_addr  out  19  linear pixel address, y*H_ACTIVE+x
- vram_q  in  12  read data {R[11:8],G[7:4],B[3:0]}
- vga_r / vga_g / vga_b  out  4 each  colour; 0 outside the active area
- vga_hs / vga_vs  out  1 each  syncs, active-low
- vblank  out  1  level, high while the line counter is >= V_ACTIVE
- vblank_start  out  1  one-clk pulse on entry to line V_ACTIVE, pixel 0

## Operation

- Counters: hc runs 0..H_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP=800. vc runs 0..V_TOTAL-1, where V_TOTAL=525. hc increments on each pix_en. When hc wraps to 0, vc increments and wraps at V_TOTAL.
- The active area is hc<H_ACTIVE && vc<V_ACTIVE.
- Address generator: an incremental counter; no multiplier.
  - It is cleared to 0 at (hc,vc)=(0,0).
  - It increments by 1 after each active pixel.
  - It reaches 307199 on the last visible pixel and then holds until the next frame.
- vram_re = 1 exactly on active ticks. vram_addr holds its last value while vram_re=0.
- Sync, undelayed:
  - hs_raw is low for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vs_raw is low for vc in 490..491.
- Delay line: active, hs_raw and vs_raw pass through an RD_LATENCY-deep shift register that advances on pix_en. This aligns them with vram_q.
- Output register: on each pix_en, one stage after the delay line:
  - rgb <= delayed_active ? vram_q : 0
  - vga_hs / vga_vs <= delayed values
- vblank and vblank_start are derived from the undelayed counters. They are deliberately ahead of the display output, which gives the drawing side the earliest possible start.
- When pix_en=0, all registers hold. vblank_start is qualified by pix_en and is therefore exactly one clk wide.

## Timing

- Reset (rstn=0 at a clk edge), with all outputs registered:
  - hc=vc=0, address counter=0, delay line cleared to inactive/high-sync.
  - vram_re=0, vram_addr=0.
  - rgb=0, vga_hs=vga_vs=1.
  - vblank=0, vblank_start=0.
- The first pix_en after reset release issues the read for (0,0).
- Latency: the read for pixel (x,y) is issued on tick N. Its colour appears on the outputs after tick N+RD_LATENCY+1. Syncs carry the same total delay.
- Reset asserted mid-frame: all of the above apply on the next clk edge regardless of pix_en. A partial frame is abandoned, and no glitch pulse is emitted on vga_hs/vga_vs beyond the reset value 1.
- Wrap: the tick after (799,524) is (0,0). The address is reloaded to 0 on that same tick.
- Frame period: 800*525 = 420000 pix_en ticks. Line period: 800 ticks.
- vram_re is combinational from registered counters. vram_addr and vram_re are stable for the whole pix_en interval.

## Structure

- Package vga_timing_pkg holds:
  - the default timing constants and derived H_TOTAL, V_TOTAL, H_SYNC_START, V_SYNC_START;
  - the 12-bit pixel colour type and its R/G/B field positions, shared with the graphics processor.
- Sub-module pipe_delay(WIDTH, DEPTH, RESET_VAL): an enable-qualified shift register with synchronous active-low reset. It is instantiated once for {active, hs_raw, vs_raw}.
- Top level holds the counters, address generator, blank/sync decode and output register.

## Test plan

- Reset then run 1 frame with pix_en=1 every clk and RD_LATENCY=1; VRAM model returns addr[11:0] -> first visible rgb is 0x000 at output tick 2, then pixel 5 of line 0 shows 0x005, and 307200 vram_re pulses occur per frame.
- Sync check -> vga_hs low for exactly 96 ticks, starting 656+2 ticks after line start; vga_vs low for 2 lines (1600 ticks) beginning at line 490 (+2 ticks); period 420000 ticks.
- Address continuity -> vram_addr at (639,0)=639, (0,1)=640, (639,479)=307199; reads 0 again at (0,0) of the next frame.
- pix_en asserted 1 clk in 4 -> outputs identical tick-for-tick to the continuous case; vblank_start is 1 clk wide, once per frame, at (0,480).
- RD_LATENCY=3 -> rgb delayed to tick N+4; colour never leaks outside the active area, with rgb=0 at the hc=640 output tick.
- rstn pulsed low at (300,200) -> next clk: vga_hs=vga_vs=1, rgb=0, vram_addr=0; after release, timing restarts at (0,0) with correct sync positions.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing defaults and the shared 12-bit pixel format.
// Used by the scanout reader and by the graphics processor side.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL =
        DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL =
        DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;

    localparam int HC_W   = 10;
    localparam int VC_W   = 10;
    localparam int ADDR_W = 19;
    localparam int PIX_W  = 12;

    typedef logic [PIX_W-1:0] pixel_t;

    localparam int R_MSB = 11;
    localparam int R_LSB = 8;
    localparam int G_MSB = 7;
    localparam int G_LSB = 4;
    localparam int B_MSB = 3;
    localparam int B_LSB = 0;

endpackage

// File: rtl/pipe_delay.sv
// Enable-qualified shift register with synchronous active-low reset.
// Reset loads every stage with RESET_VAL.
module pipe_delay #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sr_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr_q[i] <= RESET_VAL;
            end
        end else if (en_i) begin
            sr_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/vram_scanout.sv
// Raster scanout of the 12-bit frame buffer with VGA timing generation.
// Control signals are delayed to line up with the VRAM read data.
module vram_scanout
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              pix_en,
    output logic              vram_re,
    output logic [ADDR_W-1:0] vram_addr,
    input  logic [PIX_W-1:0]  vram_q,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vblank,
    output logic              vblank_start
);

    localparam int HTOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VTOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HC_W-1:0] HC_LAST = HC_W'(HTOT - 1);
    localparam logic [HC_W-1:0] HC_ACT  = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0] HS_BEG  = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0] HS_END  = HC_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VC_W-1:0] VC_LAST = VC_W'(VTOT - 1);
    localparam logic [VC_W-1:0] VC_ACT  = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0] VS_BEG  = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0] VS_END  = VC_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [HC_W-1:0]   hc_q, hc_d;
    logic [VC_W-1:0]   vc_q, vc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    pixel_t            rgb_q, rgb_d;
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic              vblank_q, vblank_d;
    logic              vbs_q, vbs_d;

    logic              active;
    logic              next_act;
    logic              hs_raw;
    logic              vs_raw;
    logic [2:0]        dly;

    assign active = (hc_q < HC_ACT) && (vc_q < VC_ACT);
    assign hs_raw = !((hc_q >= HS_BEG) && (hc_q < HS_END));
    assign vs_raw = !((vc_q >= VS_BEG) && (vc_q < VS_END));

    pipe_delay #(
        .WIDTH     (3),
        .DEPTH     (RD_LATENCY),
        .RESET_VAL (3'b011)
    ) u_dly (
        .clk  (clk),
        .rstn (rstn),
        .en_i (pix_en),
        .d_i  ({active, hs_raw, vs_raw}),
        .q_o  (dly)
    );

    always_comb begin
        hc_d     = hc_q;
        vc_d     = vc_q;
        addr_d   = addr_q;
        rgb_d    = rgb_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        vblank_d = vblank_q;
        next_act = 1'b0;
        if (pix_en) begin
            if (hc_q == HC_LAST) begin
                hc_d = '0;
                vc_d = (vc_q == VC_LAST) ? '0 : vc_q + VC_W'(1);
            end else begin
                hc_d = hc_q + HC_W'(1);
            end
            next_act = (hc_d < HC_ACT) && (vc_d < VC_ACT);
            // Step only when entering an active pixel, so blanking holds
            // the last address read and the frame end holds at the top.
            if (hc_d == '0 && vc_d == '0) begin
                addr_d = '0;
            end else if (next_act) begin
                addr_d = addr_q + ADDR_W'(1);
            end
            rgb_d    = dly[2] ? vram_q : '0;
            hs_d     = dly[1];
            vs_d     = dly[0];
            vblank_d = (vc_d >= VC_ACT);
        end
        vbs_d = pix_en && (hc_d == '0) && (vc_d == VC_ACT);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            hc_q     <= '0;
            vc_q     <= '0;
            addr_q   <= '0;
            rgb_q    <= '0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            vblank_q <= 1'b0;
            vbs_q    <= 1'b0;
        end else begin
            hc_q     <= hc_d;
            vc_q     <= vc_d;
            addr_q   <= addr_d;
            rgb_q    <= rgb_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            vblank_q <= vblank_d;
            vbs_q    <= vbs_d;
        end
    end

    // Held low while reset is applied, since counters already sit at (0,0).
    assign vram_re      = rstn && active;
    assign vram_addr    = addr_q;
    assign vga_r        = rgb_q[R_MSB:R_LSB];
    assign vga_g        = rgb_q[G_MSB:G_LSB];
    assign vga_b        = rgb_q[B_MSB:B_LSB];
    assign vga_hs       = hs_q;
    assign vga_vs       = vs_q;
    assign vblank       = vblank_q;
    assign vblank_start = vbs_q;

endmodule

// File: tb/tb_vram_scanout.sv
// Scoreboard bench for vram_scanout on a shrunken raster.
// Expected responses come from pixel-index arithmetic over the frame.
module tb_vram_scanout;

    localparam int HA  = 8;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HB  = 2;
    localparam int VA  = 6;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VB  = 2;
    localparam int LAT = 3;
    localparam int HT  = HA + HFP + HS + HB;
    localparam int VT  = VA + VFP + VS + VB;
    localparam int FT  = HT * VT;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } out_t;

    typedef struct packed {
        logic        re;
        logic [18:0] addr;
        logic        vb;
    } raw_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        pix_en = 1'b0;
    logic        vram_re;
    logic [18:0] vram_addr;
    logic [11:0] vram_q;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vblank, vblank_start;

    int   total = 0;
    int   bad = 0;
    int   k = 0;
    bit   mon_en = 0;
    bit   pe_seen = 0;
    logic [11:0] salt;
    logic [11:0] vpipe [LAT];

    out_t oq[$];
    raw_t rq[$];
    bit   vq[$];

    always #5 clk = ~clk;

    vram_scanout #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VB),
        .RD_LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .pix_en       (pix_en),
        .vram_re      (vram_re),
        .vram_addr    (vram_addr),
        .vram_q       (vram_q),
        .vga_r        (vga_r),
        .vga_g        (vga_g),
        .vga_b        (vga_b),
        .vga_hs       (vga_hs),
        .vga_vs       (vga_vs),
        .vblank       (vblank),
        .vblank_start (vblank_start)
    );

    function automatic logic [11:0] vmem(input int a);
        logic [11:0] lo;
        lo = 12'(a);
        return lo ^ salt;
    endfunction

    // VRAM: non-read ticks return noise so leaks show up on rgb
    always @(posedge clk) begin
        if (pix_en) begin
            vpipe[0] <= vram_re ? vmem(int'(vram_addr)) : 12'($urandom);
            for (int i = 1; i < LAT; i++) vpipe[i] <= vpipe[i-1];
        end
    end
    assign vram_q = vpipe[LAT-1];

    function automatic int px(input int t);
        return (t % FT) % HT;
    endfunction

    function automatic int py(input int t);
        return (t % FT) / HT;
    endfunction

    function automatic bit is_act(input int t);
        return px(t) < HA && py(t) < VA;
    endfunction

    function automatic int exp_addr(input int t);
        if (py(t) >= VA) return HA * VA - 1;
        if (px(t) >= HA) return py(t) * HA + HA - 1;
        return py(t) * HA + px(t);
    endfunction

    function automatic out_t exp_out(input int t);
        out_t o;
        o.rgb = is_act(t) ? vmem(exp_addr(t)) : 12'h000;
        o.hs  = !(px(t) >= HA + HFP && px(t) < HA + HFP + HS);
        o.vs  = !(py(t) >= VA + VFP && py(t) < VA + VFP + VS);
        return o;
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0h want %0h", nm, $time, got, want);
        end
    endtask

    always @(posedge clk) pe_seen <= pix_en && rstn;

    always @(negedge clk) begin
        out_t o;
        raw_t r;
        if (mon_en) begin
            if (pe_seen) begin
                if (oq.size() == 0 || vq.size() == 0) begin
                    chk("outq_underflow", 1, 0);
                end else begin
                    o = oq.pop_front();
                    chk("rgb", int'({vga_r, vga_g, vga_b}), int'(o.rgb));
                    chk("vga_hs", int'(vga_hs), int'(o.hs));
                    chk("vga_vs", int'(vga_vs), int'(o.vs));
                    chk("vblank_start", int'(vblank_start), int'(vq.pop_front()));
                end
            end else begin
                chk("vblank_start_idle", int'(vblank_start), 0);
            end
            if (pix_en && rstn) begin
                if (rq.size() == 0) begin
                    chk("rawq_underflow", 1, 0);
                end else begin
                    r = rq.pop_front();
                    chk("vram_re", int'(vram_re), int'(r.re));
                    chk("vram_addr", int'(vram_addr), int'(r.addr));
                    chk("vblank", int'(vblank), int'(r.vb));
                end
            end
        end
    end

    task automatic push_tick();
        raw_t r;
        r.re   = is_act(k);
        r.addr = 19'(exp_addr(k));
        r.vb   = py(k) >= VA;
        rq.push_back(r);
        vq.push_back(px(k + 1) == 0 && py(k + 1) == VA);
        oq.push_back(exp_out(k));
        k++;
    endtask

    task automatic run_ticks(input int n, input int mode);
        int  c = 0;
        int  got = 0;
        bit  pe;
        while (got < n && c < n * 40) begin
            @(posedge clk);
            #1;
            case (mode)
                0: pe = 1'b1;
                1: pe = (c % 4 == 0);
                default: pe = ($urandom_range(0, 2) == 0);
            endcase
            pix_en = pe;
            if (pe) begin
                push_tick();
                got++;
            end
            c++;
        end
        if (got < n) chk("tick_budget", got, n);
    endtask

    task automatic do_reset(input int hold);
        out_t rv;
        @(posedge clk);
        #1;
        mon_en = 0;
        rstn   = 1'b0;
        pix_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_hs", int'(vga_hs), 1);
        chk("rst_vs", int'(vga_vs), 1);
        chk("rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
        chk("rst_addr", int'(vram_addr), 0);
        chk("rst_re", int'(vram_re), 0);
        chk("rst_vblank", int'(vblank), 0);
        chk("rst_vbs", int'(vblank_start), 0);
        repeat (hold) begin
            @(posedge clk);
            #1;
            pix_en = 1'($urandom);
        end
        @(posedge clk);
        #1;
        rstn   = 1'b1;
        pix_en = 1'b0;
        oq.delete();
        rq.delete();
        vq.delete();
        k = 0;
        rv.rgb = 12'h000;
        rv.hs  = 1'b1;
        rv.vs  = 1'b1;
        repeat (LAT) oq.push_back(rv);
        mon_en = 1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        salt = 12'($urandom);
        do_reset(2);
        run_ticks(2 * FT + 5, 0);
        run_ticks(FT, 1);
        do_reset(1);
        run_ticks(2 * FT, 1);
        run_ticks(FT + 3 * HT + 5, 2);
        do_reset(3);
        run_ticks(FT + 20, 2);
        run_ticks(LAT + 2, 0);
        @(posedge clk);
        #1;
        pix_en = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        mon_en = 0;
        if (total < 12) chk("too_few_checks", total, 12);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
